// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg: shared state encoding, abort beat payload and width helper for the RX stream arbiter.
package rx_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t FWD   = 2'd1;
  localparam state_t ABORT = 2'd2;
  localparam state_t FLUSH = 2'd3;
  localparam logic [63:0] ABORT_DATA = '0;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rx_stream_arbiter_rr_next_grant.sv
// rr_next_grant: picks the first requester strictly after last_grant, wrapping cyclically.
module rr_next_grant
  import rx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int GW = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        gnt_idx,
  output logic                 any_req
);
  logic [GW-1:0] p;
  always_comb begin
    gnt_idx = '0;
    p = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      p = GW'((int'(last_grant) + k) % NUM_PORTS);
      gnt_idx = req[p] ? p : gnt_idx;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter: packet-granular round-robin mux of MAC RX streams into udp_filter, with idle watchdog abort.
module rx_stream_arbiter
  import rx_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [CNT_W-1:0]              abort_count
);
  localparam int GW = clog2_min1(NUM_PORTS);
  localparam int IW = clog2_min1(IDLE_TIMEOUT + 1);
  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   nxt;
  logic            any_req;
  logic [IW-1:0]   idle_cnt;
  logic            src_valid;
  logic            src_last;
  logic [DATA_W-1:0] src_data;
  logic            timeout;
  rr_next_grant #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .gnt_idx    (nxt),
    .any_req    (any_req)
  );
  assign src_valid = s_axis_tvalid[grant_id];
  assign src_last  = s_axis_tlast[grant_id];
  assign src_data  = s_axis_tdata[grant_id*DATA_W +: DATA_W];
  // Only source idleness counts; a downstream stall keeps tvalid high and never times out.
  assign timeout = (IDLE_TIMEOUT != 0) && !src_valid && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
  assign m_axis_tvalid = (state == FWD && src_valid) || state == ABORT;
  assign m_axis_tlast  = (state == FWD && src_last) || state == ABORT;
  assign m_axis_tuser  = state == ABORT;
  assign m_axis_tdata  = state == FWD ? src_data : state == ABORT ? DATA_W'(ABORT_DATA) : '0;
  assign s_axis_tready = {NUM_PORTS{(state == FWD && m_axis_tready) || state == FLUSH}}
                         & (NUM_PORTS'(1) << grant_id);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GW'(NUM_PORTS - 1);
      grant_id    <= '0;
      idle_cnt    <= '0;
      abort_count <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_id <= nxt;
          idle_cnt <= '0;
          state    <= FWD;
        end
        FWD: begin
          idle_cnt <= src_valid ? '0 : idle_cnt + 1'b1;
          if (src_valid && m_axis_tready && src_last) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end else if (timeout) state <= ABORT;
        end
        ABORT: if (m_axis_tready) begin
          state       <= FLUSH;
          idle_cnt    <= '0;
          abort_count <= abort_count + CNT_W'(~&abort_count);
        end
        FLUSH: begin
          idle_cnt <= src_valid ? '0 : idle_cnt + 1'b1;
          if ((src_valid && src_last) || timeout) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_stream_arbiter.sv
// tb_rx_stream_arbiter: directed checks of arbitration order, bubbles, stalls, watchdog abort/flush and reset.
module tb_rx_stream_arbiter;
  logic clk = 0;
  logic rst_n;
  logic sel;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_tready, tr_a, tr_b;
  logic        m_tready;
  logic [7:0]  m_tdata, md_a, md_b;
  logic        m_tvalid, mv_a, mv_b, m_tlast, ml_a, ml_b, m_tuser, mu_a, mu_b;
  logic        gid, gid_a, gid_b, busy, busy_a, busy_b;
  logic [15:0] acnt, ac_a, ac_b;
  int tests = 0, fails = 0, cyc = 0, nout = 0;
  logic [8:0]  mem[2][0:511];
  int wr[2], rd[2], gap_at[2], gap_len[2], gap_left[2];
  int rdy_at, rdy_len, stall_left;
  logic [31:0] ob[0:511];
  int ocyc[0:511];

  always #4 clk = ~clk;

  rx_stream_arbiter #(.NUM_PORTS(2), .DATA_W(8), .IDLE_TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(tr_a), .m_axis_tdata(md_a), .m_axis_tvalid(mv_a),
    .m_axis_tlast(ml_a), .m_axis_tuser(mu_a), .m_axis_tready(m_tready), .grant_id(gid_a),
    .busy(busy_a), .abort_count(ac_a));
  rx_stream_arbiter #(.NUM_PORTS(2), .DATA_W(8), .IDLE_TIMEOUT(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(tr_b), .m_axis_tdata(md_b), .m_axis_tvalid(mv_b),
    .m_axis_tlast(ml_b), .m_axis_tuser(mu_b), .m_axis_tready(m_tready), .grant_id(gid_b),
    .busy(busy_b), .abort_count(ac_b));

  assign s_tready = sel ? tr_b : tr_a;
  assign m_tdata  = sel ? md_b : md_a;
  assign m_tvalid = sel ? mv_b : mv_a;
  assign m_tlast  = sel ? ml_b : ml_a;
  assign m_tuser  = sel ? mu_b : mu_a;
  assign gid      = sel ? gid_b : gid_a;
  assign busy     = sel ? busy_b : busy_a;
  assign acnt     = sel ? ac_b : ac_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fb(input int tag, input int i);
    case (i)
      42: return 8'hAA;
      43: return 8'h55;
      44: return 8'h01;
      45, 46: return 8'hBB;
      default: return 8'(tag + i);
    endcase
  endfunction

  function automatic logic [31:0] word(input int g, input int u, input int l, input logic [7:0] d);
    return {16'd0, 4'(g), 2'b0, 1'(u), 1'(l), d};
  endfunction

  task automatic load_frame(input int p, input int tag);
    for (int i = 0; i < 47; i++) mem[p][wr[p] + i] = {i == 46, fb(tag, i)};
    wr[p] += 47;
  endtask

  task automatic reset_src();
    for (int p = 0; p < 2; p++) begin
      wr[p] = 0; rd[p] = 0; gap_at[p] = -1; gap_len[p] = 0; gap_left[p] = 0;
    end
    s_tvalid = 0; s_tlast = 0; s_tdata = 0;
  endtask

  task automatic tick();
    logic [1:0] hs;
    logic [8:0] b;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      ob[nout] = word(int'(gid), int'(m_tuser), int'(m_tlast), m_tdata);
      ocyc[nout] = cyc;
      nout++;
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        rd[p]++;
        if (rd[p] == gap_at[p]) gap_left[p] = gap_len[p];
      end
      b = 9'd0;
      s_tvalid[p] = 1'b0;
      if (gap_left[p] > 0) gap_left[p]--;
      else if (rd[p] < wr[p]) begin
        b = mem[p][rd[p]];
        s_tvalid[p] = 1'b1;
      end
      s_tlast[p] = b[8];
      s_tdata[p*8 +: 8] = b[7:0];
    end
    if (nout == rdy_at && rdy_len > 0) begin
      stall_left = rdy_len;
      rdy_len = 0;
    end
    m_tready = stall_left == 0;
    if (stall_left > 0) stall_left--;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b = budget;
    while (nout < n && b > 0) begin
      tick();
      b--;
    end
    chk({name, " beats"}, 32'(nout), 32'(n));
  endtask

  task automatic check_frame(input int start, input int tag, input int g, input string name);
    for (int i = 0; i < 47; i++)
      chk($sformatf("%s b%0d", name, i), ob[start + i], word(g, 0, int'(i == 46), fb(tag, i)));
  endtask

  initial begin
    sel = 0; rst_n = 0; m_tready = 1;
    rdy_at = -1; rdy_len = 0; stall_left = 0;
    reset_src();
    // 1: simultaneous requests after reset, outputs held quiet while in reset
    load_frame(0, 8'h10);
    load_frame(1, 8'h20);
    tick(); tick();
    chk("rst tready", 32'(s_tready), 0);
    chk("rst tvalid", 32'(m_tvalid), 0);
    chk("rst tlast/tuser", 32'({m_tlast, m_tuser}), 0);
    chk("rst tdata", 32'(m_tdata), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant_id", 32'(gid), 0);
    chk("rst abort_count", 32'(acnt), 0);
    rst_n = 1;
    nout = 0;
    run_until(94, 400, "t1");
    check_frame(0, 8'h10, 0, "t1 p0");
    check_frame(47, 8'h20, 1, "t1 p1");
    chk("t1 contiguous", 32'(ocyc[46] - ocyc[0]), 46);
    chk("t1 bubble", 32'(ocyc[47] - ocyc[46]), 2);
    // 2: port 0 backlog vs port 1 single frame
    repeat (3) tick();
    nout = 0;
    load_frame(0, 8'h30); load_frame(0, 8'h40); load_frame(0, 8'h50);
    load_frame(1, 8'h60);
    run_until(188, 800, "t2");
    check_frame(0, 8'h30, 0, "t2 pk0");
    check_frame(47, 8'h60, 1, "t2 pk1");
    check_frame(94, 8'h40, 0, "t2 pk2");
    check_frame(141, 8'h50, 0, "t2 pk3");
    for (int k = 1; k < 4; k++)
      chk($sformatf("t2 bubble%0d", k), 32'(ocyc[47*k] - ocyc[47*k - 1]), 2);
    // 3: long downstream stall must not trip the watchdog
    repeat (3) tick();
    nout = 0;
    rdy_at = 10; rdy_len = 40;
    load_frame(0, 8'h70);
    run_until(47, 300, "t3");
    check_frame(0, 8'h70, 0, "t3");
    chk("t3 stall gap", 32'(ocyc[10] - ocyc[9]), 41);
    chk("t3 abort_count", 32'(acnt), 0);
    // 4: port 1 goes quiet after 20 bytes -> abort beat, flush, then clean port 0 frame
    repeat (3) tick();
    nout = 0;
    gap_at[1] = wr[1] + 20; gap_len[1] = 16;
    load_frame(1, 8'h80);
    load_frame(0, 8'h90);
    run_until(68, 400, "t4");
    for (int i = 0; i < 20; i++)
      chk($sformatf("t4 p1 b%0d", i), ob[i], word(1, 0, 0, fb(8'h80, i)));
    chk("t4 abort beat", ob[20], word(1, 1, 1, 8'h00));
    chk("t4 abort latency", 32'(ocyc[20] - ocyc[19]), 17);
    check_frame(21, 8'h90, 0, "t4 p0");
    chk("t4 flushed", 32'(rd[1]), 32'(wr[1]));
    chk("t4 abort_count", 32'(acnt), 1);
    repeat (4) tick();
    chk("t4 no extra beats", 32'(nout), 68);
    chk("t4 idle", 32'(busy), 0);
    // 5: asynchronous reset mid-frame
    nout = 0;
    load_frame(0, 8'hA0);
    run_until(10, 100, "t5 pre");
    chk("t5 busy before", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("t5 tready", 32'(s_tready), 0);
    chk("t5 tvalid", 32'(m_tvalid), 0);
    chk("t5 busy", 32'(busy), 0);
    chk("t5 abort_count", 32'(acnt), 0);
    reset_src();
    load_frame(1, 8'hB0);
    load_frame(0, 8'hC0);
    tick(); tick();
    rst_n = 1;
    nout = 0;
    run_until(94, 400, "t5");
    check_frame(0, 8'hC0, 0, "t5 p0");
    check_frame(47, 8'hB0, 1, "t5 p1");
    // 6: watchdog disabled, 100-cycle source gap
    sel = 1;
    rst_n = 0;
    reset_src();
    tick(); tick();
    rst_n = 1;
    nout = 0;
    gap_at[0] = 10; gap_len[0] = 100;
    load_frame(0, 8'hD0);
    run_until(47, 400, "t6");
    check_frame(0, 8'hD0, 0, "t6");
    chk("t6 gap", 32'(ocyc[10] - ocyc[9]), 101);
    chk("t6 abort_count", 32'(acnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
